// File: rtl/me_block_scheduler.sv
// ----------------------------------------------------------------------------
// me_block_scheduler
//
// Frame-level sequencer for me_top. For each of num_blocks template blocks it
// drives blk_idx (memory bank select), runs a four-phase req/ack handshake
// with me_top, captures me_min_sad/me_min_mvec together with the block index
// and offers that result on a valid/ready port. A wait counter bounds every
// handshake phase. When it expires, the run ends with a sticky timeout_err.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          1-cycle pulse, starts a run (ignored while busy)
//   abort          level, ends the run after the current result is accepted
//   num_blocks     blocks per run, sampled on an accepted start
//   threshold      SAD threshold, sampled on an accepted start
//   me_req         request to me_top
//   me_threshold   latched threshold, held for the whole run
//   me_ack         acknowledge from me_top
//   me_min_sad     me_top result, valid while me_ack=1
//   me_min_mvec    me_top result, valid while me_ack=1
//   blk_idx        current block index
//   res_valid      result available
//   res_ready      consumer accepts result
//   res_sad        captured min_sad
//   res_mvec       captured min_mvec
//   res_idx        block index of the captured result
//   busy           run in progress
//   done           1-cycle pulse at the end of a run
//   timeout_err    sticky, cleared by the next accepted start
// ----------------------------------------------------------------------------
module me_block_scheduler #(
    parameter  int TB_LENGTH    = 16,
    parameter  int SW_LENGTH    = 64,
    parameter  int PE_OUT_WIDTH = 8,
    parameter  int BLK_WIDTH    = 10,
    parameter  int TIMEOUT      = 65535,
    localparam int SAD_WIDTH    = $clog2(TB_LENGTH**2) + PE_OUT_WIDTH,
    localparam int CNT_WIDTH    = $clog2((SW_LENGTH - TB_LENGTH + 1)**2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BLK_WIDTH-1:0] num_blocks,
    input  logic [SAD_WIDTH-1:0] threshold,
    output logic                 me_req,
    output logic [SAD_WIDTH-1:0] me_threshold,
    input  logic                 me_ack,
    input  logic [SAD_WIDTH-1:0] me_min_sad,
    input  logic [CNT_WIDTH-1:0] me_min_mvec,
    output logic [BLK_WIDTH-1:0] blk_idx,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SAD_WIDTH-1:0] res_sad,
    output logic [CNT_WIDTH-1:0] res_mvec,
    output logic [BLK_WIDTH-1:0] res_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    // The wait counter only has to reach TIMEOUT-1. It expires on the cycle
    // that would be the TIMEOUT-th cycle spent waiting in one phase.
    localparam int TO_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_REL  = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // State registers
    logic [2:0]           r_state;
    logic [TO_WIDTH-1:0]  r_wait_cnt;
    logic [BLK_WIDTH-1:0] r_num_blocks;
    logic [SAD_WIDTH-1:0] r_me_thr;
    logic                 r_me_req;
    logic [BLK_WIDTH-1:0] r_blk_idx;
    logic                 r_res_valid;
    logic [SAD_WIDTH-1:0] r_res_sad;
    logic [CNT_WIDTH-1:0] r_res_mvec;
    logic [BLK_WIDTH-1:0] r_res_idx;
    logic                 r_busy;
    logic                 r_timeout_err;

    // Next-state values
    logic [2:0]           w_state_nxt;
    logic [TO_WIDTH-1:0]  w_wait_nxt;
    logic [BLK_WIDTH-1:0] w_num_blocks_nxt;
    logic [SAD_WIDTH-1:0] w_me_thr_nxt;
    logic                 w_me_req_nxt;
    logic [BLK_WIDTH-1:0] w_blk_idx_nxt;
    logic                 w_res_valid_nxt;
    logic [SAD_WIDTH-1:0] w_res_sad_nxt;
    logic [CNT_WIDTH-1:0] w_res_mvec_nxt;
    logic [BLK_WIDTH-1:0] w_res_idx_nxt;
    logic                 w_busy_nxt;
    logic                 w_timeout_err_nxt;

    // Decoded conditions
    logic w_wait_hit;
    logic w_last_blk;
    logic w_accept;

    assign w_wait_hit = (r_wait_cnt == TO_LAST);
    // num_blocks is never 0 once a run is in progress, so the subtraction
    // cannot underflow where this is used.
    assign w_last_blk = (r_blk_idx == (r_num_blocks - BLK_WIDTH'(1)));
    assign w_accept   = r_res_valid & res_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_nxt        = '0;
        w_num_blocks_nxt  = r_num_blocks;
        w_me_thr_nxt      = r_me_thr;
        w_me_req_nxt      = r_me_req;
        w_blk_idx_nxt     = r_blk_idx;
        w_res_valid_nxt   = r_res_valid;
        w_res_sad_nxt     = r_res_sad;
        w_res_mvec_nxt    = r_res_mvec;
        w_res_idx_nxt     = r_res_idx;
        w_busy_nxt        = r_busy;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            ST_IDLE: begin
                // abort is deliberately not looked at here: start always wins
                if (start) begin
                    w_timeout_err_nxt = 1'b0;
                    if (num_blocks != '0) begin
                        w_num_blocks_nxt = num_blocks;
                        w_me_thr_nxt     = threshold;
                        w_blk_idx_nxt    = '0;
                        w_busy_nxt       = 1'b1;
                        w_me_req_nxt     = 1'b1;
                        w_state_nxt      = ST_REQ;
                    end else begin
                        // Empty frame: finish without touching me_top.
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_REQ: begin
                if (me_ack) begin
                    // Result is sampled on the same edge that first sees ack.
                    w_res_sad_nxt  = me_min_sad;
                    w_res_mvec_nxt = me_min_mvec;
                    w_res_idx_nxt  = r_blk_idx;
                    w_me_req_nxt   = 1'b0;
                    w_state_nxt    = ST_REL;
                end else if (w_wait_hit) begin
                    w_timeout_err_nxt = 1'b1;
                    w_me_req_nxt      = 1'b0;
                    w_state_nxt       = ST_DONE;
                end else begin
                    w_wait_nxt = r_wait_cnt + TO_WIDTH'(1);
                end
            end

            ST_REL: begin
                // The result is offered only once me_top has released ack,
                // so a new request can never overlap the old acknowledge.
                if (!me_ack) begin
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = ST_OUT;
                end else if (w_wait_hit) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = ST_DONE;
                end else begin
                    w_wait_nxt = r_wait_cnt + TO_WIDTH'(1);
                end
            end

            ST_OUT: begin
                if (w_accept) begin
                    w_res_valid_nxt = 1'b0;
                    if (w_last_blk || abort) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_blk_idx_nxt = r_blk_idx + BLK_WIDTH'(1);
                        w_me_req_nxt  = 1'b1;
                        w_state_nxt   = ST_REQ;
                    end
                end
            end

            ST_DONE: begin
                // blk_idx and the captured result keep their last values.
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_me_req_nxt    = 1'b0;
                w_res_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_num_blocks  <= '0;
            r_me_thr      <= '0;
            r_me_req      <= 1'b0;
            r_blk_idx     <= '0;
            r_res_valid   <= 1'b0;
            r_res_sad     <= '0;
            r_res_mvec    <= '0;
            r_res_idx     <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_num_blocks  <= w_num_blocks_nxt;
            r_me_thr      <= w_me_thr_nxt;
            r_me_req      <= w_me_req_nxt;
            r_blk_idx     <= w_blk_idx_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_res_sad     <= w_res_sad_nxt;
            r_res_mvec    <= w_res_mvec_nxt;
            r_res_idx     <= w_res_idx_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign me_req       = r_me_req;
    assign me_threshold = r_me_thr;
    assign blk_idx      = r_blk_idx;
    assign res_valid    = r_res_valid;
    assign res_sad      = r_res_sad;
    assign res_mvec     = r_res_mvec;
    assign res_idx      = r_res_idx;
    assign busy         = r_busy;
    assign done         = (r_state == ST_DONE);
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_me_block_scheduler.sv
// ----------------------------------------------------------------------------
// tb_me_block_scheduler
//
// Directed bench for me_block_scheduler. A behavioural me_top answers each
// request after a programmable latency with sad=100+blk_idx, mvec=blk_idx and
// can hold ack for extra cycles or never answer. Expected results are queued
// when a run is started and popped by a monitor when a result is accepted.
// ----------------------------------------------------------------------------
module tb_me_block_scheduler;

    localparam int BLK_W = 10;
    localparam int SAD_W = 16;
    localparam int CNT_W = 12;
    localparam int TO    = 100;

    localparam int W_DONE  = 0;
    localparam int W_VALID = 1;
    localparam int W_ACK   = 2;
    localparam int W_BLK1  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [BLK_W-1:0] num_blocks;
    logic [SAD_W-1:0] threshold;
    logic             me_req;
    logic [SAD_W-1:0] me_threshold;
    logic             me_ack;
    logic [SAD_W-1:0] me_min_sad;
    logic [CNT_W-1:0] me_min_mvec;
    logic [BLK_W-1:0] blk_idx;
    logic             res_valid;
    logic             res_ready;
    logic [SAD_W-1:0] res_sad;
    logic [CNT_W-1:0] res_mvec;
    logic [BLK_W-1:0] res_idx;
    logic             busy;
    logic             done;
    logic             timeout_err;

    me_block_scheduler #(
        .TB_LENGTH   (16),
        .SW_LENGTH   (64),
        .PE_OUT_WIDTH(8),
        .BLK_WIDTH   (BLK_W),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_blocks  (num_blocks),
        .threshold   (threshold),
        .me_req      (me_req),
        .me_threshold(me_threshold),
        .me_ack      (me_ack),
        .me_min_sad  (me_min_sad),
        .me_min_mvec (me_min_mvec),
        .blk_idx     (blk_idx),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sad     (res_sad),
        .res_mvec    (res_mvec),
        .res_idx     (res_idx),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [BLK_W-1:0] idx;
        logic [SAD_W-1:0] sad;
        logic [CNT_W-1:0] mvec;
    } exp_t;

    exp_t sb_q[$];
    int   n_results = 0;
    int   req_rises = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.idx  = BLK_W'(i);
        e.sad  = SAD_W'(100 + i);
        e.mvec = CNT_W'(i);
        sb_q.push_back(e);
    endtask

    // ---------------- me_top model (acts at posedge+1) ----------------
    int ack_lat   = 20;
    int ack_hold  = 0;
    bit never_ack = 1'b0;
    int m_cnt     = 0;
    int m_hold    = 0;

    initial begin
        me_ack      = 1'b0;
        me_min_sad  = '0;
        me_min_mvec = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                me_ack = 1'b0;
                m_cnt  = 0;
                m_hold = 0;
            end else if (me_ack) begin
                if (!me_req) begin
                    m_hold++;
                    if (m_hold > ack_hold) begin
                        me_ack = 1'b0;
                        m_hold = 0;
                    end
                end
            end else if (me_req) begin
                m_cnt++;
                if (!never_ack && m_cnt >= ack_lat) begin
                    me_ack      = 1'b1;
                    me_min_sad  = SAD_W'(100 + int'(blk_idx));
                    me_min_mvec = CNT_W'(blk_idx);
                    m_cnt       = 0;
                    m_hold      = 0;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    // ---------------- monitor (acts at negedge) ----------------
    logic             prev_req   = 1'b0;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic [SAD_W-1:0] prev_sad   = '0;
    logic [CNT_W-1:0] prev_mvec  = '0;
    logic [BLK_W-1:0] prev_idx   = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (me_req && !prev_req) begin
                req_rises++;
                check("req_rise_during_ack", 32'(me_ack), 0);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(res_valid), 1);
                check("stall_sad", 32'(res_sad), 32'(prev_sad));
                check("stall_mvec", 32'(res_mvec), 32'(prev_mvec));
                check("stall_idx", 32'(res_idx), 32'(prev_idx));
            end
            if (res_valid && res_ready) begin
                n_results++;
                check("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("res_idx", 32'(res_idx), 32'(e.idx));
                    check("res_sad", 32'(res_sad), 32'(e.sad));
                    check("res_mvec", 32'(res_mvec), 32'(e.mvec));
                end
            end
            prev_req   = me_req;
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_sad   = res_sad;
            prev_mvec  = res_mvec;
            prev_idx   = res_idx;
        end
    end

    // ---------------- stimulus helpers (act at posedge+2) ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit cond(input int which);
        case (which)
            W_DONE:  return done === 1'b1;
            W_VALID: return res_valid === 1'b1;
            W_ACK:   return me_ack === 1'b1;
            W_BLK1:  return (blk_idx === BLK_W'(1)) && (me_req === 1'b1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int max, input string tag);
        int n = 0;
        while (!cond(which) && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(cond(which)), 1);
    endtask

    task automatic run_start(input int n, input int thr);
        num_blocks = BLK_W'(n);
        threshold  = SAD_W'(thr);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int r0;
        int rr;
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_blocks = '0;
        threshold  = '0;
        res_ready  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_me_req", 32'(me_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_blk_idx", 32'(blk_idx), 0);
        check("rst_me_threshold", 32'(me_threshold), 0);
        check("rst_res_sad", 32'(res_sad), 0);
        check("rst_res_mvec", 32'(res_mvec), 0);
        check("rst_res_idx", 32'(res_idx), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Nominal: 3 blocks, always ready; a start while busy is ignored
        res_ready = 1'b1;
        push_exp(0); push_exp(1); push_exp(2);
        r0 = n_results;
        run_start(3, 4000);
        check("nom_busy", 32'(busy), 1);
        check("nom_threshold", 32'(me_threshold), 4000);
        check("nom_req", 32'(me_req), 1);
        check("nom_blk0", 32'(blk_idx), 0);
        run_start(7, 9);
        check("busy_start_threshold", 32'(me_threshold), 4000);
        wait_for(W_DONE, 2000, "nom_done");
        check("nom_nres", 32'(n_results - r0), 3);
        check("nom_sb_empty", 32'(sb_q.size()), 0);
        check("nom_last_idx", 32'(blk_idx), 2);
        tick();
        check("nom_done_pulse", 32'(done), 0);
        check("nom_busy_off", 32'(busy), 0);

        // Backpressure on block 1
        res_ready = 1'b0;
        push_exp(0); push_exp(1); push_exp(2);
        r0 = n_results;
        run_start(3, 1234);
        wait_for(W_VALID, 200, "bp_valid0");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_valid0_clr", 32'(res_valid), 0);
        check("bp_req1_next", 32'(me_req), 1);
        check("bp_blk1", 32'(blk_idx), 1);
        wait_for(W_VALID, 200, "bp_valid1");
        check("bp_idx1", 32'(res_idx), 1);
        for (int k = 0; k < 50; k++) begin
            tick();
            check("bp_stall_req", 32'(me_req), 0);
            check("bp_stall_valid", 32'(res_valid), 1);
        end
        res_ready = 1'b1;
        tick();
        check("bp_req2_next", 32'(me_req), 1);
        check("bp_blk2", 32'(blk_idx), 2);
        check("bp_valid1_clr", 32'(res_valid), 0);
        wait_for(W_DONE, 500, "bp_done");
        check("bp_nres", 32'(n_results - r0), 3);
        tick();

        // Four-phase: ack held 10 cycles after req falls; start+abort in IDLE
        ack_hold = 10;
        push_exp(0);
        r0 = n_results;
        abort = 1'b1;
        run_start(1, 500);
        abort = 1'b0;
        check("fp_start_wins", 32'(busy), 1);
        wait_for(W_ACK, 200, "fp_ack");
        n = 0;
        while (me_ack === 1'b1 && n < 100) begin
            tick();
            n++;
            if (me_ack === 1'b1) begin
                check("fp_no_req", 32'(me_req), 0);
                check("fp_no_valid", 32'(res_valid), 0);
            end
        end
        check("fp_ack_fell", 32'(me_ack), 0);
        check("fp_valid_not_yet", 32'(res_valid), 0);
        tick();
        check("fp_valid_1cyc", 32'(res_valid), 1);
        wait_for(W_DONE, 200, "fp_done");
        check("fp_nres", 32'(n_results - r0), 1);
        ack_hold = 0;
        tick();

        // Zero blocks
        rr = req_rises;
        run_start(0, 77);
        check("zero_done", 32'(done), 1);
        check("zero_req", 32'(me_req), 0);
        tick();
        check("zero_done_off", 32'(done), 0);
        tick();
        check("zero_no_req", 32'(req_rises - rr), 0);

        // Abort while idle has no effect
        abort = 1'b1;
        repeat (3) tick();
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_done", 32'(done), 0);
        abort = 1'b0;

        // Abort during block 1 REQ
        push_exp(0); push_exp(1);
        r0 = n_results;
        run_start(5, 4000);
        wait_for(W_BLK1, 500, "ab_in_blk1");
        abort = 1'b1;
        wait_for(W_DONE, 500, "ab_done");
        abort = 1'b0;
        check("ab_nres", 32'(n_results - r0), 2);
        check("ab_sb_empty", 32'(sb_q.size()), 0);
        check("ab_blk_idx", 32'(blk_idx), 1);
        tick();

        // Timeout: model never acks
        never_ack = 1'b1;
        run_start(2, 300);
        check("to_req", 32'(me_req), 1);
        repeat (99) tick();
        check("to_not_yet", 32'(timeout_err), 0);
        check("to_req_held", 32'(me_req), 1);
        tick();
        check("to_err", 32'(timeout_err), 1);
        check("to_done", 32'(done), 1);
        check("to_req_drop", 32'(me_req), 0);
        check("to_no_valid", 32'(res_valid), 0);
        never_ack = 1'b0;
        tick();
        check("to_sticky", 32'(timeout_err), 1);
        check("to_busy_off", 32'(busy), 0);
        push_exp(0);
        r0 = n_results;
        run_start(1, 300);
        check("to_cleared", 32'(timeout_err), 0);
        wait_for(W_DONE, 500, "to_rerun_done");
        check("to_rerun_nres", 32'(n_results - r0), 1);
        tick();

        // Reset in the middle of block 1 REQ
        push_exp(0);
        r0 = n_results;
        run_start(2, 555);
        wait_for(W_BLK1, 500, "mr_in_blk1");
        rst_n = 1'b0;
        #1;
        check("mr_req", 32'(me_req), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_valid", 32'(res_valid), 0);
        check("mr_blk_idx", 32'(blk_idx), 0);
        check("mr_threshold", 32'(me_threshold), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("mr_nres", 32'(n_results - r0), 1);
        check("mr_sb_empty", 32'(sb_q.size()), 0);
        push_exp(0);
        r0 = n_results;
        run_start(1, 555);
        check("mr_restart_blk", 32'(blk_idx), 0);
        check("mr_restart_req", 32'(me_req), 1);
        wait_for(W_DONE, 500, "mr_restart_done");
        check("mr_restart_nres", 32'(n_results - r0), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
